// File: rtl/panel_loader_if.sv
// Host byte-stream bus into the panel loader.
//   in_data   : host byte
//   in_strobe : in_data valid this cycle
//   in_ready  : loader accepts a byte this cycle (byte taken when strobe && ready)
// master = host side, slave = panel_loader side.
interface panel_loader_if;
    logic [7:0] in_data;
    logic       in_strobe;
    logic       in_ready;

    modport master (output in_data, output in_strobe, input in_ready);
    modport slave  (input in_data, input in_strobe, output in_ready);
endinterface

// File: rtl/panel_loader.sv
// panel_loader: decodes a BIN-style framed host byte stream and drives the PDP-8/I
// front-panel switch inputs (sr, ifsr, dfsr, load_addr, dep, start) with settle and
// pulse timing.
//
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   host (slave)    : in_data / in_strobe / in_ready byte handshake
//   run             : core run indicator; SETUP stalls while it is high
//   sr, ifsr, dfsr  : switch register and field switches
//   load_addr, dep, start : one-hot switch pulses, PULSE_CYCLES long
//   busy            : SETUP, PULSE or GAP in progress
//   err             : sticky framing error
//   dep_count       : deposits issued, mod 4096
//   checksum        : running payload sum (0 unless enabled)
//
// Build option: define PANEL_LOADER_CHECKSUM_EN to enable the payload checksum
// and the 0x82 clear command.
module panel_loader #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES  = 8
) (
    input  logic          clk,
    input  logic          rst,
    panel_loader_if.slave host,
    input  logic          run,
    output logic [11:0]   sr,
    output logic [2:0]    ifsr,
    output logic [2:0]    dfsr,
    output logic          load_addr,
    output logic          dep,
    output logic          start,
    output logic          busy,
    output logic          err,
    output logic [11:0]   dep_count,
    output logic [11:0]   checksum
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES
                                                                    : PULSE_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] PulseLast  = CntW'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StLow, StSetup, StPulse, StGap} state_e;
    typedef enum logic [1:0] {OpLoad, OpDep, OpStart} op_e;

    state_e          state_q;
    op_e             op_q;
    logic [CntW-1:0] cnt_q;
    logic            run_pend_q;   // RUN: a start operation follows the current load
    logic [5:0]      hi_q;
    logic            hi_origin_q;
    logic [11:0]     sr_q;
    logic [11:0]     start_vec_q;
    logic [2:0]      ifsr_q;
    logic [2:0]      dfsr_q;
    logic            load_addr_q;
    logic            dep_q;
    logic            start_q;
    logic            err_q;
    logic [11:0]     dep_count_q;
    logic            ready_q;

    logic            accept;
    logic [1:0]      tag;
    logic [5:0]      payload;
    logic [11:0]     word;

    assign accept  = host.in_strobe && ready_q;
    assign tag     = host.in_data[7:6];
    assign payload = host.in_data[5:0];
    assign word    = {hi_q, payload};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            op_q        <= OpLoad;
            cnt_q       <= '0;
            run_pend_q  <= 1'b0;
            hi_q        <= '0;
            hi_origin_q <= 1'b0;
            sr_q        <= '0;
            start_vec_q <= '0;
            ifsr_q      <= '0;
            dfsr_q      <= '0;
            load_addr_q <= 1'b0;
            dep_q       <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            dep_count_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StLow: begin
                    // ready_q is 0 only in the first cycle out of reset
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (state_q == StLow && tag == 2'b00) begin
                            sr_q       <= word;
                            run_pend_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= StSetup;
                            ready_q    <= 1'b0;
                            if (hi_origin_q) begin
                                start_vec_q <= word;
                                op_q        <= OpLoad;
                            end else begin
                                op_q <= OpDep;
                            end
                        end else begin
                            // A non-low byte in LOW drops the pending half and is
                            // decoded as a fresh byte.
                            if (state_q == StLow) begin
                                err_q <= 1'b1;
                            end
                            state_q <= StIdle;
                            unique case (tag)
                                2'b11: begin
                                    ifsr_q <= host.in_data[5:3];
                                    dfsr_q <= host.in_data[5:3];
                                end
                                2'b10: begin
                                    if (host.in_data == 8'h81) begin
                                        sr_q       <= start_vec_q;
                                        op_q       <= OpLoad;
                                        run_pend_q <= 1'b1;
                                        cnt_q      <= '0;
                                        state_q    <= StSetup;
                                        ready_q    <= 1'b0;
                                    end
                                end
                                default: begin
                                    hi_q        <= payload;
                                    hi_origin_q <= tag[0];
                                    state_q     <= StLow;
                                end
                            endcase
                        end
                    end
                end
                StSetup: begin
                    // Deposits wait for the core to halt: any run cycle restarts settle.
                    if (run) begin
                        cnt_q <= '0;
                    end else if (cnt_q == SettleLast) begin
                        cnt_q   <= '0;
                        state_q <= StPulse;
                        case (op_q)
                            OpLoad: load_addr_q <= 1'b1;
                            OpDep: begin
                                dep_q       <= 1'b1;
                                dep_count_q <= dep_count_q + 12'd1;
                            end
                            default: start_q <= 1'b1;
                        endcase
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPulse: begin
                    if (cnt_q == PulseLast) begin
                        cnt_q       <= '0;
                        load_addr_q <= 1'b0;
                        dep_q       <= 1'b0;
                        start_q     <= 1'b0;
                        state_q     <= StGap;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == SettleLast) begin
                        cnt_q <= '0;
                        if (run_pend_q) begin
                            run_pend_q <= 1'b0;
                            op_q       <= OpStart;
                            state_q    <= StSetup;
                        end else begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef PANEL_LOADER_CHECKSUM_EN
    logic [11:0] checksum_q;

    // Every accepted 00/01 byte carries a payload half, whether it completes a word
    // or starts a new one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum_q <= '0;
        end else if (accept && host.in_data == 8'h82) begin
            checksum_q <= '0;
        end else if (accept && !host.in_data[7]) begin
            checksum_q <= checksum_q + {6'd0, payload};
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 12'd0;
`endif

    assign host.in_ready = ready_q;
    assign sr            = sr_q;
    assign ifsr          = ifsr_q;
    assign dfsr          = dfsr_q;
    assign load_addr     = load_addr_q;
    assign dep           = dep_q;
    assign start         = start_q;
    assign err           = err_q;
    assign dep_count     = dep_count_q;
    assign busy          = (state_q == StSetup) || (state_q == StPulse) || (state_q == StGap);

endmodule

// File: tb/tb_panel_loader.sv
module tb_panel_loader;
    localparam int S = 4;
    localparam int P = 8;

    logic        clk;
    logic        rst;
    logic        run;
    logic [11:0] sr;
    logic [2:0]  ifsr;
    logic [2:0]  dfsr;
    logic        load_addr;
    logic        dep;
    logic        start;
    logic        busy;
    logic        err;
    logic [11:0] dep_count;
    logic [11:0] checksum;

    panel_loader_if host_if ();

    panel_loader #(
        .SETTLE_CYCLES(S),
        .PULSE_CYCLES (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .host     (host_if),
        .run      (run),
        .sr       (sr),
        .ifsr     (ifsr),
        .dfsr     (dfsr),
        .load_addr(load_addr),
        .dep      (dep),
        .start    (start),
        .busy     (busy),
        .err      (err),
        .dep_count(dep_count),
        .checksum (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] sw;
    assign sw = {start, dep, load_addr};

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    // Drive a byte at a negedge once in_ready is seen; returns at the negedge of the
    // cycle right after acceptance.
    task automatic send(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        while (!host_if.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) check("send_ready_timeout", int'(host_if.in_ready), 1);
        host_if.in_data   = b;
        host_if.in_strobe = 1'b1;
        @(negedge clk);
        host_if.in_strobe = 1'b0;
    endtask

    // Per-switch activity over n cycles following an acceptance (k=1 is the first).
    int first_hi[3];
    int last_hi[3];
    int n_hi[3];
    int ready_k;
    int sr_bad;

    task automatic observe(input int n, input logic [11:0] exp_sr);
        for (int s = 0; s < 3; s++) begin
            first_hi[s] = 0;
            last_hi[s]  = 0;
            n_hi[s]     = 0;
        end
        ready_k = -1;
        sr_bad  = 0;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                if (sw[s]) begin
                    if (first_hi[s] == 0) first_hi[s] = k;
                    last_hi[s] = k;
                    n_hi[s]++;
                end
            end
            if (host_if.in_ready && ready_k < 0) ready_k = k;
            if (sr != exp_sr) sr_bad++;
        end
    endtask

    task automatic check_single(input int idx);
        check("op_first_high", first_hi[idx], S + 1);
        check("op_last_high", last_hi[idx], S + P);
        check("op_high_cycles", n_hi[idx], P);
        check("op_other_switches", n_hi[0] + n_hi[1] + n_hi[2] - n_hi[idx], 0);
        check("op_ready_return", ready_k, 2 * S + P + 1);
        check("op_sr_stable", sr_bad, 0);
    endtask

    // ---------------- stream-level reference model ----------------
    typedef struct {
        logic [2:0]  sw;
        logic [11:0] sr;
    } pulse_t;

    pulse_t      exp_q[$];
    logic        m_have_hi;
    logic [5:0]  m_hi;
    logic        m_hi_org;
    logic [11:0] m_start;
    logic [2:0]  m_fld;
    logic        m_err;
    logic [11:0] m_dc;
    logic [11:0] m_sum;

    task automatic model_byte(input logic [7:0] b);
        logic [11:0] w;
        if (m_have_hi && b[7:6] == 2'b00) begin
            w = {m_hi, b[5:0]};
            if (m_hi_org) begin
                m_start = w;
                exp_q.push_back(pulse_t'{3'b001, w});
            end else begin
                exp_q.push_back(pulse_t'{3'b010, w});
                m_dc = m_dc + 12'd1;
            end
            m_have_hi = 1'b0;
            m_sum = m_sum + {6'd0, b[5:0]};
        end else begin
            if (m_have_hi) m_err = 1'b1;
            m_have_hi = 1'b0;
            if (b[7:6] == 2'b11) begin
                m_fld = b[5:3];
            end else if (b == 8'h81) begin
                exp_q.push_back(pulse_t'{3'b001, m_start});
                exp_q.push_back(pulse_t'{3'b100, m_start});
            end else if (b == 8'h82) begin
                m_sum = 12'd0;
            end else if (!b[7]) begin
                m_have_hi = 1'b1;
                m_hi      = b[5:0];
                m_hi_org  = b[6];
                m_sum     = m_sum + {6'd0, b[5:0]};
            end
        end
    endtask

    function automatic int exp_csum(input logic [11:0] s);
`ifdef PANEL_LOADER_CHECKSUM_EN
        return int'(s);
`else
        return 0 * int'(s);
`endif
    endfunction

    // Pulse monitor for the randomized phase.
    logic       mon_en = 1'b0;
    logic [2:0] mon_prev;
    int         mon_len;
    pulse_t     mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sw != 3'b000 && mon_prev == 3'b000) begin
                check("rand_onehot", $countones(sw), 1);
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_pulse", int'(sw), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rand_switch", int'(sw), int'(mon_e.sw));
                    check("rand_sr", int'(sr), int'(mon_e.sr));
                end
                mon_len = 1;
            end else if (sw != 3'b000) begin
                mon_len++;
            end else if (mon_prev != 3'b000) begin
                check("rand_pulse_len", mon_len, P);
            end
            mon_prev = sw;
        end else begin
            mon_prev = 3'b000;
            mon_len  = 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  pre;
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          idx;
        logic [11:0] sr;
        logic [2:0]  fld;
    } vec_t;

    vec_t        vecs[6];
    logic [11:0] exp_dc;
    logic [11:0] exp_sum;
    int          dep_hi;
    int          busy_lo;
    logic [7:0]  rb;
    int          r;

    initial begin
        vecs[0] = '{8'h80, 8'h42, 8'h00, 0, 12'h080, 3'd0};
        vecs[1] = '{8'h80, 8'h3F, 8'h3F, 1, 12'hFFF, 3'd0};
        vecs[2] = '{8'hD0, 8'h41, 8'h10, 0, 12'h050, 3'd2};
        vecs[3] = '{8'hFF, 8'h2A, 8'h15, 1, 12'hA95, 3'd7};
        vecs[4] = '{8'hC8, 8'h00, 8'h01, 1, 12'h001, 3'd1};
        vecs[5] = '{8'h80, 8'h45, 8'h02, 0, 12'h142, 3'd1};

        rst               = 1'b0;
        run               = 1'b0;
        host_if.in_data   = 8'h00;
        host_if.in_strobe = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_sr", int'(sr), 0);
        check("rst_ifsr", int'(ifsr), 0);
        check("rst_dfsr", int'(dfsr), 0);
        check("rst_load_addr", int'(load_addr), 0);
        check("rst_dep", int'(dep), 0);
        check("rst_start", int'(start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_dep_count", int'(dep_count), 0);
        check("rst_checksum", int'(checksum), 0);
        check("rst_in_ready", int'(host_if.in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", int'(host_if.in_ready), 1);

        // Table-driven word loads/deposits
        exp_dc  = 12'd0;
        exp_sum = 12'd0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].pre);
            check("tbl_ifsr", int'(ifsr), int'(vecs[i].fld));
            check("tbl_dfsr", int'(dfsr), int'(vecs[i].fld));
            check("tbl_pre_not_busy", int'(busy), 0);
            send(vecs[i].hi);
            send(vecs[i].lo);
            check("tbl_sr_after_accept", int'(sr), int'(vecs[i].sr));
            observe(2 * S + P + 1, vecs[i].sr);
            check_single(vecs[i].idx);
            if (vecs[i].idx == 1) exp_dc = exp_dc + 12'd1;
            exp_sum = exp_sum + {6'd0, vecs[i].hi[5:0]} + {6'd0, vecs[i].lo[5:0]};
            check("tbl_dep_count", int'(dep_count), int'(exp_dc));
            check("tbl_err", int'(err), 0);
        end
        check("tbl_checksum", int'(checksum), exp_csum(exp_sum));

        // Framing error: 0x01 then 0x45 re-decoded as origin high half
        send(8'h01);
        check("frm_err_before", int'(err), 0);
        send(8'h45);
        check("frm_err_set", int'(err), 1);
        send(8'h02);
        observe(2 * S + P + 1, 12'h142);
        check_single(0);
        exp_sum = exp_sum + 12'd8;
        check("frm_checksum", int'(checksum), exp_csum(exp_sum));

        // Deposit while the core runs
        run = 1'b1;
        send(8'h05);
        send(8'h21);
        check("run_sr_immediate", int'(sr), 12'h161);
        dep_hi  = 0;
        busy_lo = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            if (dep) dep_hi++;
            if (!busy) busy_lo++;
        end
        check("run_dep_held_low", dep_hi, 0);
        check("run_busy_held", busy_lo, 0);
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("run_dep_not_yet", int'(dep), 0);
        @(negedge clk);
        check("run_dep_rises", int'(dep), 1);
        exp_dc = exp_dc + 12'd1;
        check("run_dep_count", int'(dep_count), int'(exp_dc));
        for (int i = 0; i < 50 && !host_if.in_ready; i++) @(negedge clk);
        check("run_ready_back", int'(host_if.in_ready), 1);

        // RUN command with checksum clear
        send(8'h82);
        check("cmd_checksum_clear", int'(checksum), 0 * exp_csum(exp_sum) + exp_csum(
`ifdef PANEL_LOADER_CHECKSUM_EN
            12'd0
`else
            exp_sum
`endif
            ));
        exp_sum = 12'd0;
        send(8'h41);
        send(8'h10);
        observe(2 * S + P + 1, 12'h050);
        check_single(0);
        send(8'h81);
        observe(4 * S + 2 * P + 1, 12'h050);
        check("run_cmd_load_first", first_hi[0], S + 1);
        check("run_cmd_load_len", n_hi[0], P);
        check("run_cmd_start_first", first_hi[2], 3 * S + P + 1);
        check("run_cmd_start_last", last_hi[2], 3 * S + 2 * P);
        check("run_cmd_no_dep", n_hi[1], 0);
        check("run_cmd_ready", ready_k, 4 * S + 2 * P + 1);
        check("run_cmd_sr_stable", sr_bad, 0);
        check("run_cmd_checksum", int'(checksum), exp_csum(12'h011));
        send(8'h82);
        check("run_cmd_checksum_clr", int'(checksum), 0);

        // Reset in the middle of a deposit pulse
        send(8'h00);
        send(8'h07);
        repeat (S + 1) @(negedge clk);
        check("mid_rst_dep_active", int'(dep), 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_dep", int'(dep), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_sr", int'(sr), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_dep_count", int'(dep_count), 0);
        check("mid_rst_ready", int'(host_if.in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_back", int'(host_if.in_ready), 1);

        // Randomized stream against the reference model
        m_have_hi = 1'b0;
        m_hi      = '0;
        m_hi_org  = 1'b0;
        m_start   = '0;
        m_fld     = '0;
        m_err     = 1'b0;
        m_dc      = '0;
        m_sum     = '0;
        mon_en    = 1'b1;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      rb = {2'b00, 6'($urandom)};
            else if (r < 55) rb = {2'b01, 6'($urandom)};
            else if (r < 65) rb = {2'b11, 6'($urandom)};
            else if (r < 75) rb = 8'h80;
            else if (r < 81) rb = 8'h81;
            else if (r < 87) rb = 8'h82;
            else             rb = {2'b10, 6'($urandom)};
            send(rb);
            model_byte(rb);
        end
        for (int i = 0; i < 400 && !(host_if.in_ready && !busy && exp_q.size() == 0); i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("rand_queue_drained", exp_q.size(), 0);
        check("rand_err", int'(err), int'(m_err));
        check("rand_dep_count", int'(dep_count), int'(m_dc));
        check("rand_ifsr", int'(ifsr), int'(m_fld));
        check("rand_dfsr", int'(dfsr), int'(m_fld));
        check("rand_checksum", int'(checksum), exp_csum(m_sum));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
